display_scan_controller: RTL and testbench

- Time-multiplexes one shared BinaryToDisplay decoder across DIGITS common-anode/cathode 7-segment digits on the sensor board.
- Holds a double-buffered frame of hex nibbles and per-digit blank bits, and scans digits round-robin.
- Presents the current nibble to the decoder and drives one digit enable at a time, with a blanking gap between digits against ghosting.
- New values from the sensor readout path are committed atomically at frame boundaries only.

---
 rtl/display_scan_controller.sv | 115 +++++++++++
 tb/tb_display_scan_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Round-robin 7-segment scan controller: double-buffered nibble frame, one shared
// decoder, and a blanking gap before each digit slot to avoid ghosting.
module display_scan_controller #(
   parameter int DIGITS            = 4,
   parameter int CLOCKS_PER_DIGIT  = 50000,
   parameter int BLANK_CLOCKS      = 500,
   parameter bit ENABLE_ACTIVE_LOW = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  value_load,
   output logic                  load_pending,
   output logic [3:0]            binary_number,
   output logic [DIGITS-1:0]     digit_enable,
   output logic                  frame_start
);

   localparam int MAX_CLOCKS = (CLOCKS_PER_DIGIT > BLANK_CLOCKS) ? CLOCKS_PER_DIGIT : BLANK_CLOCKS;
   localparam int CW = (MAX_CLOCKS > 1) ? $clog2(MAX_CLOCKS) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CLOCKS - 1);
   localparam logic [CW-1:0]     SHOW_LAST  = CW'(CLOCKS_PER_DIGIT - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] EN_OFF     = {DIGITS{ENABLE_ACTIVE_LOW}};

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t                   state, state_nxt;
   logic [CW-1:0]            cnt, cnt_nxt;
   logic [IW-1:0]            idx, idx_nxt;
   logic                     leave_show, wrap, commit;
   logic [DIGITS-1:0][3:0]   value_in_nib;
   logic [DIGITS-1:0][3:0]   active_val, shadow_val, commit_val;
   logic [DIGITS-1:0]        active_blank, shadow_blank, commit_blank;
   logic [DIGITS-1:0]        en_nxt;
   logic [3:0]               bin_nxt;

   assign value_in_nib = value_in;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt + CW'(1);
      idx_nxt    = idx;
      leave_show = 1'b0;
      wrap       = 1'b0;
      case (state)
         ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nxt = ST_SHOW;
               cnt_nxt   = '0;
            end
         end
         ST_SHOW: begin
            if (cnt == SHOW_LAST) begin
               state_nxt  = ST_BLANK;
               cnt_nxt    = '0;
               leave_show = 1'b1;
               wrap       = (idx == IDX_LAST);
               idx_nxt    = wrap ? '0 : idx + IW'(1);
            end
         end
         default: state_nxt = ST_BLANK;
      endcase

      // A load landing on the wrap edge bypasses the shadow so it is not lost.
      commit       = wrap & (load_pending | value_load);
      commit_val   = value_load ? value_in_nib : shadow_val;
      commit_blank = value_load ? blank_in : shadow_blank;
      bin_nxt      = commit ? commit_val[0] : active_val[idx_nxt];

      // idx only moves on SHOW->BLANK, so the current index is the one entering SHOW.
      en_nxt = EN_OFF;
      if (state_nxt == ST_SHOW && !active_blank[idx])
         en_nxt[idx] = ~EN_OFF[idx];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_BLANK;
         cnt           <= '0;
         idx           <= '0;
         active_val    <= '0;
         shadow_val    <= '0;
         active_blank  <= '1;
         shadow_blank  <= '1;
         load_pending  <= 1'b0;
         binary_number <= 4'h0;
         digit_enable  <= EN_OFF;
         frame_start   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         digit_enable <= en_nxt;
         frame_start  <= wrap;
         if (leave_show)
            binary_number <= bin_nxt;
         if (commit) begin
            active_val   <= commit_val;
            active_blank <= commit_blank;
         end
         if (value_load) begin
            shadow_val   <= value_in_nib;
            shadow_blank <= blank_in;
         end
         if (wrap)
            load_pending <= 1'b0;
         else if (value_load)
            load_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with DIGITS=4, 4 show clocks, 2 blank clocks.
module tb_display_scan_controller;

   localparam int FRAME = 24;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] value_in;
   logic [3:0]  blank_in;
   logic        value_load;
   logic        load_pending;
   logic [3:0]  binary_number;
   logic [3:0]  digit_enable;
   logic        frame_start;

   display_scan_controller #(
      .DIGITS(4), .CLOCKS_PER_DIGIT(4), .BLANK_CLOCKS(2), .ENABLE_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock), .reset(reset), .value_in(value_in), .blank_in(blank_in),
      .value_load(value_load), .load_pending(load_pending), .binary_number(binary_number),
      .digit_enable(digit_enable), .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   typedef struct {
      int             ld1;
      logic [15:0]    v1;
      logic [3:0]     b1;
      int             ld2;
      logic [15:0]    v2;
      logic [3:0]     b2;
      logic [3:0][3:0] exp_bin;
      logic [3:0][3:0] exp_en;
   } vec_t;

   vec_t            vecs[4];
   int              errors = 0;
   int              checks = 0;
   int              cyc = 0;
   logic            pend_exp;
   logic [3:0][3:0] disp_bin;
   logic [3:0][3:0] disp_en;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   // Expected outputs derived from frame position and the data the bench expects on display.
   task automatic check_cycle();
      int p, d, sub;
      p   = cyc % FRAME;
      d   = p / 6;
      sub = p % 6;
      check("digit_enable", 32'(digit_enable), (sub >= 2) ? 32'(disp_en[d]) : 32'hF);
      check("binary_number", 32'(binary_number), 32'(disp_bin[d]));
      check("frame_start", 32'(frame_start), 32'((cyc != 0) && (p == 0)));
      check("load_pending", 32'(load_pending), 32'(pend_exp));
   endtask

   task automatic run_frame(input int ld1, input logic [15:0] v1, input logic [3:0] b1,
                            input int ld2, input logic [15:0] v2, input logic [3:0] b2);
      logic ld;
      for (int p = 0; p < FRAME; p++) begin
         check_cycle();
         ld = 1'b0;
         if (p == ld1) begin
            value_in = v1; blank_in = b1; value_load = 1'b1; ld = 1'b1;
         end
         if (p == ld2) begin
            value_in = v2; blank_in = b2; value_load = 1'b1; ld = 1'b1;
         end
         step();
         value_load = 1'b0;
         if (cyc % FRAME == 0) pend_exp = 1'b0;
         else if (ld)          pend_exp = 1'b1;
      end
   endtask

   initial begin
      vecs[0] = '{3,  16'h4C5B, 4'b0000, -1, 16'h0000, 4'b0000,
                  {4'h4, 4'hC, 4'h5, 4'hB}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
      vecs[1] = '{3,  16'h1234, 4'b0000, 15, 16'h5678, 4'b0000,
                  {4'h5, 4'h6, 4'h7, 4'h8}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
      vecs[2] = '{5,  16'h0042, 4'b1100, -1, 16'h0000, 4'b0000,
                  {4'h0, 4'h0, 4'h4, 4'h2}, {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
      vecs[3] = '{23, 16'h000F, 4'b0000, -1, 16'h0000, 4'b0000,
                  {4'h0, 4'h0, 4'h0, 4'hF}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};

      reset = 1'b1; value_in = '0; blank_in = '0; value_load = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0; cyc = 0; pend_exp = 1'b0;
      disp_bin = '0; disp_en = 16'hFFFF;

      // Idle after reset: everything blank, frame_start every 24 cycles.
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      for (int i = 0; i < 4; i++) begin
         run_frame(vecs[i].ld1, vecs[i].v1, vecs[i].b1, vecs[i].ld2, vecs[i].v2, vecs[i].b2);
         disp_bin = vecs[i].exp_bin;
         disp_en  = vecs[i].exp_en;
      end

      // Reset during digit 2 SHOW with a pending load: the shadow must be discarded.
      for (int p = 0; p < 15; p++) begin
         check_cycle();
         if (p == 2) begin
            value_in = 16'h9ABC; blank_in = 4'b0000; value_load = 1'b1;
         end
         step();
         if (p == 2) begin
            value_load = 1'b0; pend_exp = 1'b1;
         end
      end
      check_cycle();
      reset = 1'b1;
      step();
      reset = 1'b0; cyc = 0; pend_exp = 1'b0;
      disp_bin = '0; disp_en = 16'hFFFF;
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
